// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pkg
// Description : Shared RV32M definitions for the multiply/divide unit:
//               data width, funct3 encodings and the FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    localparam int XLEN = 32;

    // RV32M funct3 encodings
    localparam logic [2:0] C_F3_MUL    = 3'b000;
    localparam logic [2:0] C_F3_MULH   = 3'b001;
    localparam logic [2:0] C_F3_MULHSU = 3'b010;
    localparam logic [2:0] C_F3_MULHU  = 3'b011;
    localparam logic [2:0] C_F3_DIV    = 3'b100;
    localparam logic [2:0] C_F3_DIVU   = 3'b101;
    localparam logic [2:0] C_F3_REM    = 3'b110;
    localparam logic [2:0] C_F3_REMU   = 3'b111;

    // Iterative unit FSM states
    localparam logic [1:0] C_ST_IDLE = 2'd0;
    localparam logic [1:0] C_ST_CALC = 2'd1;
    localparam logic [1:0] C_ST_DONE = 2'd2;

endpackage
`default_nettype wire

// File: rtl/muldiv_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit_if
// Description : Request/response bundle between the register-file side and
//               the multiply/divide unit.
//               start/funct3/op_a/op_b/rd_in : operation request
//               busy/done/result/rd_out/we   : status and write-back
// Revision    : 1.0 - initial release
// ============================================================================
interface muldiv_unit_if;
    import riscv_pkg::*;

    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [4:0]      rd_in;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    logic [4:0]      rd_out;
    logic            we;

    modport master (
        output start, funct3, op_a, op_b, rd_in,
        input  busy, done, result, rd_out, we
    );

    modport slave (
        input  start, funct3, op_a, op_b, rd_in,
        output busy, done, result, rd_out, we
    );

endinterface
`default_nettype wire

// File: rtl/muldiv_signfix.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_signfix
// Description : Conditional two's-complement negation. Produces operand
//               magnitudes on the way in and restores the result sign on
//               the way out.
//               value : input word      neg   : negate when high
//               fixed : value or -value
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_signfix #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] value,
    input  logic             neg,
    output logic [WIDTH-1:0] fixed
);

    assign fixed = neg ? ({WIDTH{1'b0}} - value) : value;

endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Iterative RV32M multiply/divide unit. Radix-2 shift-add
//               multiply and restoring divide, 32 CALC cycles each, on
//               operand magnitudes with a final sign fix-up. Divide-by-zero
//               and signed overflow skip CALC and finish in one cycle.
// Ports       : clk - rising-edge clock
//               rst - asynchronous active-low reset
//               bus - muldiv_unit_if.slave (request in, write-back out)
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit
    import riscv_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    muldiv_unit_if.slave bus
);

    logic [1:0]        r_state;
    logic [1:0]        w_state_next;
    logic [4:0]        r_cnt;
    logic [2:0]        r_f3;
    logic              r_neg;
    logic [XLEN-1:0]   r_opnd;
    logic [2*XLEN-1:0] r_acc;
    logic [XLEN-1:0]   r_result;
    logic [4:0]        r_rd;

    logic              w_a_signed;
    logic              w_b_signed;
    logic              w_a_neg;
    logic              w_b_neg;
    logic              w_res_neg;
    logic              w_is_div;
    logic              w_div0;
    logic              w_ovf;
    logic              w_bypass;
    logic [XLEN-1:0]   w_a_mag;
    logic [XLEN-1:0]   w_b_mag;
    logic [XLEN-1:0]   w_bypass_val;
    logic [XLEN:0]     w_mul_sum;
    logic [XLEN:0]     w_div_shift;
    logic [XLEN:0]     w_div_diff;
    logic [2*XLEN-1:0] w_mul_next;
    logic [2*XLEN-1:0] w_div_next;
    logic [2*XLEN-1:0] w_acc_next;
    logic [2*XLEN-1:0] w_fix_in;
    logic [2*XLEN-1:0] w_fix_out;
    logic [XLEN-1:0]   w_result_final;
    logic              w_busy;
    logic              w_done;
    logic              w_we;

    // ---------------- request decode ----------------
    always_comb begin
        w_a_signed = 1'b0;
        w_b_signed = 1'b0;
        case (bus.funct3)
            C_F3_MULH, C_F3_DIV, C_F3_REM: begin
                w_a_signed = 1'b1;
                w_b_signed = 1'b1;
            end
            C_F3_MULHSU: w_a_signed = 1'b1;
            C_F3_MUL, C_F3_MULHU, C_F3_DIVU, C_F3_REMU: ;
        endcase
    end

    assign w_a_neg   = w_a_signed & bus.op_a[XLEN-1];
    assign w_b_neg   = w_b_signed & bus.op_b[XLEN-1];
    // Remainder takes the dividend's sign; everything else the XOR of both
    // (unsigned operands contribute 0, so MULHSU reduces to sign(a)).
    assign w_res_neg = (bus.funct3 == C_F3_REM) ? w_a_neg : (w_a_neg ^ w_b_neg);

    assign w_is_div  = bus.funct3[2];
    assign w_div0    = w_is_div && (bus.op_b == '0);
    // w_a_signed together with w_is_div selects exactly DIV/REM
    assign w_ovf     = w_is_div && w_a_signed &&
                       (bus.op_a == {1'b1, {(XLEN-1){1'b0}}}) && (bus.op_b == '1);
    assign w_bypass  = w_div0 | w_ovf;

    // funct3[1] distinguishes REM/REMU from DIV/DIVU
    always_comb begin
        if (w_div0) begin
            w_bypass_val = bus.funct3[1] ? bus.op_a : '1;
        end else begin
            w_bypass_val = bus.funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
        end
    end

    muldiv_signfix #(.WIDTH(XLEN)) u_fix_a (
        .value (bus.op_a),
        .neg   (w_a_neg),
        .fixed (w_a_mag)
    );

    muldiv_signfix #(.WIDTH(XLEN)) u_fix_b (
        .value (bus.op_b),
        .neg   (w_b_neg),
        .fixed (w_b_mag)
    );

    // ---------------- iteration datapath ----------------
    // r_acc = {hi, lo}. Multiply: lo holds the multiplier and shifts out
    // LSB-first while hi accumulates. Divide: hi is the partial remainder,
    // lo shifts the dividend out and the quotient bits in.
    assign w_mul_sum   = {1'b0, r_acc[2*XLEN-1:XLEN]} +
                         (r_acc[0] ? {1'b0, r_opnd} : {(XLEN+1){1'b0}});
    assign w_mul_next  = {w_mul_sum, r_acc[XLEN-1:1]};

    assign w_div_shift = r_acc[2*XLEN-1:XLEN-1];
    assign w_div_diff  = w_div_shift - {1'b0, r_opnd};
    assign w_div_next  = w_div_diff[XLEN]
                       ? {w_div_shift[XLEN-1:0], r_acc[XLEN-2:0], 1'b0}
                       : {w_div_diff[XLEN-1:0],  r_acc[XLEN-2:0], 1'b1};

    assign w_acc_next  = r_f3[2] ? w_div_next : w_mul_next;

    // Multiplies negate the full 64-bit product so MULH* high words are
    // correct; divides negate only the selected quotient/remainder.
    assign w_fix_in = !r_f3[2] ? w_acc_next
                    : {{XLEN{1'b0}}, r_f3[1] ? w_acc_next[2*XLEN-1:XLEN]
                                             : w_acc_next[XLEN-1:0]};

    muldiv_signfix #(.WIDTH(2*XLEN)) u_fix_res (
        .value (w_fix_in),
        .neg   (r_neg),
        .fixed (w_fix_out)
    );

    always_comb begin
        case (r_f3)
            C_F3_MULH, C_F3_MULHSU, C_F3_MULHU: w_result_final = w_fix_out[2*XLEN-1:XLEN];
            default:                            w_result_final = w_fix_out[XLEN-1:0];
        endcase
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= C_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            C_ST_IDLE: begin
                if (bus.start) begin
                    w_state_next = w_bypass ? C_ST_DONE : C_ST_CALC;
                end
            end
            C_ST_CALC: begin
                if (r_cnt == 5'd31) begin
                    w_state_next = C_ST_DONE;
                end
            end
            C_ST_DONE: w_state_next = C_ST_IDLE;
            default:   w_state_next = C_ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        w_busy = (r_state == C_ST_CALC) || (r_state == C_ST_DONE);
        w_done = (r_state == C_ST_DONE);
        w_we   = w_done && (r_rd != 5'd0);
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt    <= 5'd0;
            r_f3     <= 3'd0;
            r_neg    <= 1'b0;
            r_opnd   <= '0;
            r_acc    <= '0;
            r_result <= '0;
            r_rd     <= 5'd0;
        end else begin
            case (r_state)
                C_ST_IDLE: begin
                    if (bus.start) begin
                        r_cnt  <= 5'd0;
                        r_f3   <= bus.funct3;
                        r_neg  <= w_res_neg;
                        r_rd   <= bus.rd_in;
                        r_opnd <= w_is_div ? w_b_mag : w_a_mag;
                        r_acc  <= {{XLEN{1'b0}}, w_is_div ? w_a_mag : w_b_mag};
                        if (w_bypass) begin
                            r_result <= w_bypass_val;
                        end
                    end
                end
                C_ST_CALC: begin
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == 5'd31) begin
                        r_result <= w_result_final;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy   = w_busy;
    assign bus.done   = w_done;
    assign bus.we     = w_we;
    assign bus.result = r_result;
    assign bus.rd_out = r_rd;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_unit
// Description : Directed self-checking bench for muldiv_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;
    import riscv_pkg::*;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    logic [31:0] res;
    int          lat;
    logic        wes;
    logic [4:0]  rds;

    muldiv_unit_if bus ();

    muldiv_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Launch one operation and wait (bounded) for done. lat is the cycle
    // number after the accepting edge in which done was seen (0 = never).
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          output logic [31:0] r, output int l,
                          output logic w, output logic [4:0] d);
        @(negedge clk);
        bus.start  = 1'b1;
        bus.funct3 = f3;
        bus.op_a   = a;
        bus.op_b   = b;
        bus.rd_in  = rd;
        @(posedge clk);
        @(negedge clk);
        // Scramble inputs: the unit must work from its latched copies
        bus.start  = 1'b0;
        bus.funct3 = ~f3;
        bus.op_a   = ~a;
        bus.op_b   = b ^ 32'h5A5A_5A5A;
        bus.rd_in  = ~rd;
        l = 0;
        r = 32'hDEAD_BEEF;
        w = 1'b0;
        d = 5'd0;
        for (int k = 1; k <= 40; k++) begin
            if (bus.done) begin
                l = k;
                r = bus.result;
                w = bus.we;
                d = bus.rd_out;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2 rst = 1'b0;
        #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.done); end
        checks++; if (bus.we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b expected 0", bus.we); end
        checks++; if (bus.result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h expected 00000000", bus.result); end
        checks++; if (bus.rd_out !== 5'd0) begin errors++; $display("FAIL reset_rd_out: got %0d expected 0", bus.rd_out); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_mul();
        run_op(C_F3_MUL, 32'd7, 32'd6, 5'd5, res, lat, wes, rds);
        checks++; if (res !== 32'h0000_002A) begin errors++; $display("FAIL mul_result: got %h expected 0000002a", res); end
        checks++; if (lat !== 33) begin errors++; $display("FAIL mul_latency: got %0d expected 33", lat); end
        checks++; if (wes !== 1'b1) begin errors++; $display("FAIL mul_we: got %b expected 1", wes); end
        checks++; if (rds !== 5'd5) begin errors++; $display("FAIL mul_rd_out: got %0d expected 5", rds); end
    endtask

    task automatic test_mulh();
        run_op(C_F3_MULH, 32'h8000_0000, 32'h8000_0000, 5'd1, res, lat, wes, rds);
        checks++; if (res !== 32'h4000_0000) begin errors++; $display("FAIL mulh_result: got %h expected 40000000", res); end
        run_op(C_F3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, res, lat, wes, rds);
        checks++; if (res !== 32'hFFFF_FFFE) begin errors++; $display("FAIL mulhu_result: got %h expected fffffffe", res); end
        run_op(C_F3_MULHSU, 32'hFFFF_FFFF, 32'h0000_0002, 5'd1, res, lat, wes, rds);
        checks++; if (res !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mulhsu_result: got %h expected ffffffff", res); end
        // -3 * 5 = -15; low word 0xFFFFFFF1
        run_op(C_F3_MUL, 32'hFFFF_FFFD, 32'd5, 5'd1, res, lat, wes, rds);
        checks++; if (res !== 32'hFFFF_FFF1) begin errors++; $display("FAIL mul_neg_result: got %h expected fffffff1", res); end
    endtask

    task automatic test_div();
        run_op(C_F3_DIV, 32'hFFFF_FFF9, 32'd2, 5'd3, res, lat, wes, rds);
        checks++; if (res !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_result: got %h expected fffffffd", res); end
        checks++; if (lat !== 33) begin errors++; $display("FAIL div_latency: got %0d expected 33", lat); end
        run_op(C_F3_REM, 32'hFFFF_FFF9, 32'd2, 5'd3, res, lat, wes, rds);
        checks++; if (res !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rem_result: got %h expected ffffffff", res); end
        run_op(C_F3_DIVU, 32'd100, 32'd7, 5'd3, res, lat, wes, rds);
        checks++; if (res !== 32'd14) begin errors++; $display("FAIL divu_result: got %h expected 0000000e", res); end
        run_op(C_F3_REMU, 32'd100, 32'd7, 5'd3, res, lat, wes, rds);
        checks++; if (res !== 32'd2) begin errors++; $display("FAIL remu_result: got %h expected 00000002", res); end
    endtask

    task automatic test_bypass();
        run_op(C_F3_DIVU, 32'd5, 32'd0, 5'd8, res, lat, wes, rds);
        checks++; if (res !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divu0_result: got %h expected ffffffff", res); end
        checks++; if (lat !== 1) begin errors++; $display("FAIL divu0_latency: got %0d expected 1", lat); end
        run_op(C_F3_REMU, 32'd5, 32'd0, 5'd8, res, lat, wes, rds);
        checks++; if (res !== 32'd5) begin errors++; $display("FAIL remu0_result: got %h expected 00000005", res); end
        checks++; if (lat !== 1) begin errors++; $display("FAIL remu0_latency: got %0d expected 1", lat); end
        run_op(C_F3_REM, 32'hFFFF_FFF9, 32'd0, 5'd8, res, lat, wes, rds);
        checks++; if (res !== 32'hFFFF_FFF9) begin errors++; $display("FAIL rem0_result: got %h expected fffffff9", res); end
        run_op(C_F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, res, lat, wes, rds);
        checks++; if (res !== 32'h8000_0000) begin errors++; $display("FAIL div_ovf_result: got %h expected 80000000", res); end
        checks++; if (lat !== 1) begin errors++; $display("FAIL div_ovf_latency: got %0d expected 1", lat); end
        run_op(C_F3_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, res, lat, wes, rds);
        checks++; if (res !== 32'h0) begin errors++; $display("FAIL rem_ovf_result: got %h expected 00000000", res); end
        checks++; if (lat !== 1) begin errors++; $display("FAIL rem_ovf_latency: got %0d expected 1", lat); end
    endtask

    task automatic test_hold_and_rd0();
        run_op(C_F3_MUL, 32'd3, 32'd4, 5'd0, res, lat, wes, rds);
        checks++; if (res !== 32'd12) begin errors++; $display("FAIL rd0_result: got %h expected 0000000c", res); end
        checks++; if (wes !== 1'b0) begin errors++; $display("FAIL rd0_we: got %b expected 0", wes); end
        run_op(C_F3_MUL, 32'd9, 32'd9, 5'd17, res, lat, wes, rds);
        repeat (3) begin
            @(negedge clk);
            bus.op_a  = $urandom;
            bus.op_b  = $urandom;
            bus.rd_in = 5'd2;
        end
        @(negedge clk);
        checks++; if (bus.result !== 32'd81) begin errors++; $display("FAIL hold_result: got %h expected 00000051", bus.result); end
        checks++; if (bus.rd_out !== 5'd17) begin errors++; $display("FAIL hold_rd_out: got %0d expected 17", bus.rd_out); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL hold_busy: got %b expected 0", bus.busy); end
    endtask

    task automatic test_ignore_start();
        int ndone;
        int first_k;
        logic [31:0] r1;
        ndone = 0; first_k = 0; r1 = 32'h0;
        @(negedge clk);
        bus.start = 1'b1; bus.funct3 = C_F3_DIVU; bus.op_a = 32'd100; bus.op_b = 32'd7; bus.rd_in = 5'd7;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        for (int k = 1; k <= 45; k++) begin
            if (k == 5) begin
                bus.start = 1'b1; bus.funct3 = C_F3_MUL; bus.op_a = 32'd7; bus.op_b = 32'd6; bus.rd_in = 5'd9;
            end
            if (k == 7) bus.start = 1'b0;
            if (bus.done) begin
                ndone++;
                if (ndone == 1) begin r1 = bus.result; first_k = k; end
            end
            @(negedge clk);
        end
        checks++; if (ndone !== 1) begin errors++; $display("FAIL ignore_done_count: got %0d expected 1", ndone); end
        checks++; if (r1 !== 32'd14) begin errors++; $display("FAIL ignore_result: got %h expected 0000000e", r1); end
        checks++; if (first_k !== 33) begin errors++; $display("FAIL ignore_latency: got %0d expected 33", first_k); end
    endtask

    task automatic test_back_to_back();
        int l1;
        int l2;
        logic [31:0] r1;
        logic [31:0] r2;
        l1 = 0; l2 = 0; r1 = 32'h0; r2 = 32'h0;
        @(negedge clk);
        bus.start = 1'b1; bus.funct3 = C_F3_MUL; bus.op_a = 32'd7; bus.op_b = 32'd6; bus.rd_in = 5'd2;
        @(posedge clk);
        @(negedge clk);
        for (int k = 1; k <= 40; k++) begin
            if (bus.done) begin l1 = k; r1 = bus.result; break; end
            @(negedge clk);
        end
        // start still high while done: must only be taken in the following IDLE cycle
        bus.funct3 = C_F3_DIVU; bus.op_a = 32'd100; bus.op_b = 32'd7; bus.rd_in = 5'd9;
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL b2b_idle_busy: got %b expected 0", bus.busy); end
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (bus.done) begin l2 = k; r2 = bus.result; break; end
            @(negedge clk);
        end
        checks++; if (r1 !== 32'd42) begin errors++; $display("FAIL b2b_first_result: got %h expected 0000002a", r1); end
        checks++; if (l1 !== 33) begin errors++; $display("FAIL b2b_first_latency: got %0d expected 33", l1); end
        checks++; if (r2 !== 32'd14) begin errors++; $display("FAIL b2b_second_result: got %h expected 0000000e", r2); end
        checks++; if (l2 !== 33) begin errors++; $display("FAIL b2b_second_latency: got %0d expected 33", l2); end
    endtask

    task automatic test_abort();
        int nwe;
        int l;
        logic [31:0] r;
        nwe = 0; l = 0; r = 32'h0;
        @(negedge clk);
        bus.start = 1'b1; bus.funct3 = C_F3_MUL; bus.op_a = 32'h1234_5678; bus.op_b = 32'd5; bus.rd_in = 5'd4;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL abort_done: got %b expected 0", bus.done); end
        checks++; if (bus.result !== 32'h0) begin errors++; $display("FAIL abort_result: got %h expected 00000000", bus.result); end
        checks++; if (bus.we !== 1'b0) begin errors++; $display("FAIL abort_we: got %b expected 0", bus.we); end
        @(negedge clk);
        rst = 1'b1;
        bus.start = 1'b1; bus.funct3 = C_F3_MUL; bus.op_a = 32'd3; bus.op_b = 32'd3; bus.rd_in = 5'd6;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (bus.we) nwe++;
            if (bus.done && l == 0) begin l = k; r = bus.result; end
            @(negedge clk);
        end
        checks++; if (r !== 32'd9) begin errors++; $display("FAIL abort_new_result: got %h expected 00000009", r); end
        checks++; if (l !== 33) begin errors++; $display("FAIL abort_new_latency: got %0d expected 33", l); end
        checks++; if (nwe !== 1) begin errors++; $display("FAIL abort_we_count: got %0d expected 1", nwe); end
    endtask

    initial begin
        errors     = 0;
        checks     = 0;
        bus.start  = 1'b0;
        bus.funct3 = 3'd0;
        bus.op_a   = 32'h0;
        bus.op_b   = 32'h0;
        bus.rd_in  = 5'd0;
        test_reset();
        test_mul();
        test_mulh();
        test_div();
        test_bypass();
        test_hold_and_rd0();
        test_ignore_start();
        test_back_to_back();
        test_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset, named clk and rst.
REQ-002 Port clk, input, 1 bit: rising-edge clock shared with the register file.
REQ-003 Port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 Port start, input, 1 bit: request a new operation; sampled only in IDLE.
REQ-005 Port funct3, input, 3 bits: RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 Port op_a, input, 32 bits: rs1 operand, taken from register-file RD1.
REQ-007 Port op_b, input, 32 bits: rs2 operand, taken from register-file RD2.
REQ-008 Port rd_in, input, 5 bits: destination register index.
REQ-009 Port busy, output, 1 bit: high in CALC and DONE.
REQ-010 Port done, output, 1 bit: one-cycle pulse; result valid.
REQ-011 Port result, output, 32 bits: write-back data for register-file WD3.
REQ-012 Port rd_out, output, 5 bits: latched rd_in, driving register-file A3.
REQ-013 Port we, output, 1 bit: register-file WE3; equals done, and is forced to 0 when rd_out==0.

Function
REQ-014 FSM states SHALL be IDLE, CALC and DONE; transitions: IDLE->CALC on start; CALC->DONE when the iteration counter reaches 31; DONE->IDLE unconditionally.
REQ-015 On an IDLE rising edge with start=1, the block SHALL latch funct3, op_a, op_b and rd_in; later input changes have no effect.
REQ-016 Multiply SHALL be radix-2 shift-add over 32 CALC cycles with a 64-bit product.
- MUL returns the low 32 bits.
- MULH, MULHSU and MULHU return the high 32 bits.
REQ-017 Divide SHALL be restoring, 32 CALC cycles, yielding a 32-bit quotient and a 32-bit remainder.
REQ-018 Signed ops SHALL operate on magnitudes and negate the result afterwards.
- MULH: both operands signed. MULHSU: op_a signed, op_b unsigned.
- DIV quotient sign = sign(a) XOR sign(b).
- REM remainder sign = sign(a).
REQ-019 Normal latency: done SHALL be high in the 33rd cycle after the accepting edge (32 CALC + 1 DONE).
REQ-020 Divide-by-zero (op_b==0) SHALL bypass CALC (IDLE->DONE, done in the cycle after the accepting edge).
- DIV/DIVU result = 0xFFFFFFFF.
- REM/REMU result = op_a.
REQ-021 Signed overflow (DIV/REM, op_a=0x80000000, op_b=0xFFFFFFFF) SHALL bypass CALC.
- DIV result = 0x80000000.
- REM result = 0.
REQ-022 result and rd_out SHALL hold their value from DONE until the next accepted start.
REQ-023 start asserted while busy=1 SHALL be ignored, not queued.
REQ-024 start and done in the same cycle: done is in the DONE state, so start SHALL be ignored; it is accepted on the following IDLE edge.

Reset
REQ-025 rst=0 SHALL immediately force the following, regardless of clk:
- state to IDLE;
- counter, busy, done and we to 0;
- result to 0x00000000 and rd_out to 0.
REQ-026 Reset during CALC SHALL abort the operation with no write-back pulse; after release the block accepts start on the first rising edge.

Structure
REQ-027 The funct3 encodings, the FSM state encoding and XLEN=32 SHALL be defined in the shared package riscv_pkg.
REQ-028 The datapath SHALL be a single module.
- The magnitude/sign-fixup logic is the one natural sub-module: muldiv_signfix, combinational, used on both input and output.

Verification
REQ-029 MUL 7 x 6 -> result=0x0000002A; done high exactly 33 cycles after start; we=1 when rd_in=5.
REQ-030 MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 0x00000002 -> 0xFFFFFFFF.
REQ-031 DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
REQ-032 DIVU 5/0 -> 0xFFFFFFFF and REMU 5/0 -> 5, each with done one cycle after start; DIV 0x80000000/0xFFFFFFFF -> 0x80000000 and REM -> 0, also with 1-cycle latency.
REQ-033 Second start pulse during CALC -> ignored; exactly one done, carrying the first operation's result.
REQ-034 rst=0 at CALC cycle 10 -> busy=0, done=0, result=0 before the next edge; no we pulse; a new MUL 3 x 3 after release -> 9.
